serial_adder: RTL

- Parametrised digit-serial adder/subtractor with accumulate mode; successor to the single-bit combinational adder in our tile.
- Operands are latched on `start` and added LSB-first, DIGIT bits per cycle, through one full-adder slice and a registered carry.
- Result, carry and signed overflow are reported with a start/busy/done handshake.
- Sits behind the tile's top-level pin wrapper, which maps ui_in/uio_in to operands and control, and maps results to uo_out.

---
 rtl/serial_adder.sv | 94 +++++++++
 1 files changed

// File: rtl/serial_adder.sv
// Digit-serial adder/subtractor: operands are added LSB-first, DIGIT bits per cycle,
// through one adder slice with a registered carry. Supports accumulate into the sum register.
module serial_adder #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  input  logic             acc,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out,
  output logic             overflow,
  output logic             busy,
  output logic             done
);

  localparam int N     = WIDTH / DIGIT;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]       state;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [WIDTH-1:0] res;
  logic             carry;
  logic [CNT_W-1:0] cnt;

  logic [DIGIT:0]   dsum;
  logic             msb_cin;
  logic             last;
  logic [WIDTH-1:0] res_next;

  // The carry into the top bit of a digit is recovered from that bit's inputs and sum,
  // so it is valid for any DIGIT without a separate partial adder.
  always_comb begin
    dsum     = {1'b0, op_a[DIGIT-1:0]} + {1'b0, op_b[DIGIT-1:0]} + {{DIGIT{1'b0}}, carry};
    msb_cin  = op_a[DIGIT-1] ^ op_b[DIGIT-1] ^ dsum[DIGIT-1];
    last     = (cnt == CNT_W'(N - 1));
    res_next = (res >> DIGIT) | (WIDTH'(dsum[DIGIT-1:0]) << (WIDTH - DIGIT));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      op_a      <= '0;
      op_b      <= '0;
      res       <= '0;
      carry     <= 1'b0;
      cnt       <= '0;
      sum       <= '0;
      carry_out <= 1'b0;
      overflow  <= 1'b0;
    end else if (ena) begin
      case (state)
        IDLE: begin
          if (start) begin
            op_a  <= acc ? sum : a;
            op_b  <= sub ? ~b : b;
            carry <= sub;
            cnt   <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          op_a  <= op_a >> DIGIT;
          op_b  <= op_b >> DIGIT;
          res   <= res_next;
          carry <= dsum[DIGIT];
          cnt   <= cnt + CNT_W'(1);
          if (last) begin
            sum       <= res_next;
            carry_out <= dsum[DIGIT];
            overflow  <= msb_cin ^ dsum[DIGIT];
            state     <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign busy = (state != IDLE);
  assign done = (state == DONE);

endmodule
